// File: rtl/dma_periph_pkg.sv
// Shared types, sizes and the source-index mapping for the DMA peripheral
// request/clear controller.
package dma_periph_pkg;

    localparam int NUM_CH    = 31;
    localparam int CH_ID_W   = 5;
    localparam int NUM_SRC   = 2 * NUM_CH;
    localparam int SRC_IDX_W = $clog2(NUM_SRC);

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2,
        CLR   = 2'd3
    } state_e;

    // Arbitration order is ch1tx, ch1rx, ch2tx, ... i.e. 2*(ch-1)+dir.
    function automatic logic [SRC_IDX_W-1:0] src_idx(input logic [CH_ID_W-1:0] ch,
                                                     input dir_e dir);
        src_idx = {ch - 5'd1, dir};
    endfunction

endpackage

// File: rtl/dma_periph_req_ctrl_if.sv
// Grant offer / completion handshake between the request controller (master)
// and the DMA channel engine (slave).
interface dma_periph_req_ctrl_if;
    import dma_periph_pkg::*;

    logic               ch_req_valid;
    logic               ch_req_ready;
    logic [CH_ID_W-1:0] ch_req_id;
    logic               ch_req_dir;
    logic               ch_done_valid;
    logic [CH_ID_W-1:0] ch_done_id;
    logic               ch_done_dir;

    modport master (
        output ch_req_valid, ch_req_id, ch_req_dir,
        input  ch_req_ready, ch_done_valid, ch_done_id, ch_done_dir
    );

    modport slave (
        input  ch_req_valid, ch_req_id, ch_req_dir,
        output ch_req_ready, ch_done_valid, ch_done_id, ch_done_dir
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin search over all request sources, starting at ptr
// and wrapping from the last source back to source 0.
module dma_rr_arbiter
    import dma_periph_pkg::*;
(
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic [NUM_SRC-1:0]   grant,
    output logic [SRC_IDX_W-1:0] grant_idx,
    output logic                 grant_valid
);

    // First set request at or after ptr, modulo NUM_SRC.
    always_comb begin
        logic [SRC_IDX_W:0] sum_s;
        logic [SRC_IDX_W:0] pos_s;
        logic               found_s;
        found_s   = 1'b0;
        grant_idx = '0;
        sum_s     = '0;
        pos_s     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum_s     = {1'b0, ptr} + 7'(i);
            pos_s     = (sum_s >= 7'(NUM_SRC)) ? (sum_s - 7'(NUM_SRC)) : sum_s;
            grant_idx = (req[pos_s[SRC_IDX_W-1:0]] && !found_s) ? pos_s[SRC_IDX_W-1:0] : grant_idx;
            found_s   = found_s | req[pos_s[SRC_IDX_W-1:0]];
        end
        grant_valid = found_s;
        grant       = found_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

endmodule

// File: rtl/dma_periph_req_ctrl.sv
// DMA-side peripheral request/clear handshake: samples level requests,
// round-robin grants one source at a time and pulses its clear on completion.
// Optional DMA_PERIPH_REQ_SYNC_EN adds a 2-flop synchronizer on the requests.
module dma_periph_req_ctrl
    import dma_periph_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH:1]       periph_tx_req,
    input  logic [NUM_CH:1]       periph_rx_req,
    output logic [NUM_CH:1]       periph_tx_clr,
    output logic [NUM_CH:1]       periph_rx_clr,
    input  logic [NUM_CH:1]       ch_enable,
    dma_periph_req_ctrl_if.master ch,
    output logic                  busy,
    output logic                  err
);

    logic [NUM_CH:1]       tx_lvl_s, rx_lvl_s, tx_clr_n_s, rx_clr_n_s;
    logic [NUM_CH:1]       tx_clr_r, rx_clr_r;
    logic [NUM_SRC-1:0]    src_req_s, src_en_s, clr_vec_s, in_service_s, lock_set_s;
    logic [NUM_SRC-1:0]    pending_r, lockout_r, cur_grant_r, arb_grant_s;
    logic [SRC_IDX_W-1:0]  ptr_r, arb_idx_s;
    logic                  arb_valid_s, latch_s, done_match_s, err_set_s;
    logic [CH_ID_W-1:0]    id_r;
    logic                  dir_r, valid_r, busy_r, err_r;
    state_e                state_r, state_n;

`ifdef DMA_PERIPH_REQ_SYNC_EN
    logic [NUM_CH:1] tx_meta_r, tx_sync_r, rx_meta_r, rx_sync_r;

    // Two-flop synchronizer for the asynchronous peripheral request levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_meta_r <= '0;
            tx_sync_r <= '0;
            rx_meta_r <= '0;
            rx_sync_r <= '0;
        end else begin
            tx_meta_r <= periph_tx_req;
            tx_sync_r <= tx_meta_r;
            rx_meta_r <= periph_rx_req;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign tx_lvl_s = tx_sync_r;
    assign rx_lvl_s = rx_sync_r;
`else
    assign tx_lvl_s = periph_tx_req;
    assign rx_lvl_s = periph_rx_req;
`endif

    // Interleave per-channel vectors into source order and back.
    always_comb begin
        src_req_s  = '0;
        src_en_s   = '0;
        tx_clr_n_s = '0;
        rx_clr_n_s = '0;
        for (int c = 1; c <= NUM_CH; c++) begin
            src_req_s[src_idx(CH_ID_W'(c), DIR_TX)] = tx_lvl_s[c];
            src_req_s[src_idx(CH_ID_W'(c), DIR_RX)] = rx_lvl_s[c];
            src_en_s[src_idx(CH_ID_W'(c), DIR_TX)]  = ch_enable[c];
            src_en_s[src_idx(CH_ID_W'(c), DIR_RX)]  = ch_enable[c];
            tx_clr_n_s[c] = clr_vec_s[src_idx(CH_ID_W'(c), DIR_TX)];
            rx_clr_n_s[c] = clr_vec_s[src_idx(CH_ID_W'(c), DIR_RX)];
        end
    end

    dma_rr_arbiter u_arb (
        .req         (pending_r),
        .ptr         (ptr_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    assign done_match_s = (ch.ch_done_id == id_r) && (ch.ch_done_dir == dir_r);
    assign err_set_s    = ch.ch_done_valid && !((state_r == BUSY) && done_match_s);
    assign latch_s      = (state_r == IDLE) && arb_valid_s;
    assign in_service_s = (state_r != IDLE) ? cur_grant_r : '0;
    assign lock_set_s   = (state_r == CLR) ? cur_grant_r : '0;
    assign clr_vec_s    = (state_n == CLR) ? cur_grant_r : '0;

    // Next-state logic; a mismatched done only flags err and keeps BUSY.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    state_n = arb_valid_s ? OFFER : IDLE;
            OFFER:   state_n = ch.ch_req_ready ? BUSY : OFFER;
            BUSY:    state_n = (ch.ch_done_valid && done_match_s) ? CLR : BUSY;
            CLR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, sampling, lockout, winner latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            pending_r   <= '0;
            lockout_r   <= '0;
            cur_grant_r <= '0;
            ptr_r       <= '0;
            id_r        <= '0;
            dir_r       <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            tx_clr_r    <= '0;
            rx_clr_r    <= '0;
        end else begin
            state_r   <= state_n;
            pending_r <= src_req_s & src_en_s & ~lockout_r & ~in_service_s;
            // Lockout survives only while the level stays high after its clear.
            lockout_r <= (lockout_r | lock_set_s) & src_req_s;
            err_r     <= err_r | err_set_s;
            valid_r   <= (state_n == OFFER);
            busy_r    <= (state_n != IDLE);
            tx_clr_r  <= tx_clr_n_s;
            rx_clr_r  <= rx_clr_n_s;
            if (latch_s) begin
                cur_grant_r <= arb_grant_s;
                id_r        <= arb_idx_s[SRC_IDX_W-1:1] + 5'd1;
                dir_r       <= arb_idx_s[0];
                ptr_r       <= (arb_idx_s == 6'(NUM_SRC - 1)) ? 6'd0 : (arb_idx_s + 6'd1);
            end
        end
    end

    assign ch.ch_req_valid = valid_r;
    assign ch.ch_req_id    = id_r;
    assign ch.ch_req_dir   = dir_r;
    assign periph_tx_clr   = tx_clr_r;
    assign periph_rx_clr   = rx_clr_r;
    assign busy            = busy_r;
    assign err             = err_r;

endmodule

// File: doc/dma_periph_req_ctrl.md
Name: dma_periph_req_ctrl

Overview:
DMA-controller end of the peripheral request/clear handshake. Peripherals drive level requests on periph_tx_req/periph_rx_req[31:1]. This block samples them and round-robin arbitrates across 62 sources (31 channels × tx/rx). It offers one winner at a time to the channel engine and, when the engine reports completion, pulses the matching periph_*_clr bit for one cycle.

Parameters:
NUM_CH, 31, number of peripheral channels; channel indices 1..NUM_CH, index 0 unused
CH_ID_W, 5, width of channel id fields

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
periph_tx_req  in  [31:1]  level tx requests from peripherals
periph_rx_req  in  [31:1]  level rx requests from peripherals
periph_tx_clr  out  [31:1]  one-cycle tx clear pulses
periph_rx_clr  out  [31:1]  one-cycle rx clear pulses
ch_enable  in  [31:1]  per-channel enable; disabled channels are never granted
ch_req_valid  out  1  grant offer to channel engine
ch_req_ready  in  1  engine accepts offer
ch_req_id  out  CH_ID_W  granted channel (1..31)
ch_req_dir  out  1  0=tx, 1=rx
ch_done_valid  in  1  engine completed the in-service transfer
ch_done_id  in  CH_ID_W  completed channel
ch_done_dir  in  1  completed direction
busy  out  1  state != IDLE
err  out  1  sticky: done mismatched with in-service id/dir

Behaviour:
- Reset (reset==0, async): all outputs 0; pending, lockout and rr pointer cleared; FSM→IDLE. Reset mid-transfer abandons the transfer and issues no clr.
- Sampling: pending[s] <= req[s] & ch_enable & ~lockout[s] & ~in_service[s], registered every clk.
- Source order for arbitration: ch1tx, ch1rx, ch2tx, ... ch31rx (index 2*(ch-1)+dir). Round robin: search starts at last winner+1 and wraps 61→0.
- FSM:
  - IDLE: any pending → latch winner, advance pointer, go OFFER.
  - OFFER: ch_req_valid=1; id/dir stable. On ready → BUSY.
  - BUSY: wait ch_done_valid with matching id/dir → CLR. Mismatched done → set err, stay BUSY.
  - CLR: pulse the clr bit for exactly one cycle, set lockout[s], go IDLE.
- Lockout: clears when req[s] is sampled 0. This blocks re-grant on a stale level. A peripheral that keeps req high after clr is not re-granted until it drops for ≥1 cycle.
- Latency (no sync): req sampled high at edge k → ch_req_valid high after edge k+1. Done at edge d → clr high during cycle after d. Next grant no earlier than 1 cycle after CLR.
- Disabling a channel while in OFFER/BUSY does not abort; the transfer completes normally.
- tx and rx of the same channel pending together: granted in rr order, never concurrently.
- ch_done_valid in IDLE/OFFER: sets err, otherwise ignored.
- err clears only on reset.

Optional Feature:
DMA_PERIPH_REQ_SYNC_EN
- Defined: 2-flop synchronizer on periph_tx_req/periph_rx_req before sampling. Grant latency increases by 2 cycles. Lockout release also observes the synchronized value.
- Undefined: inputs are sampled directly, with the latency as stated above.

Decomposition:
- Package dma_periph_pkg holds:
  - NUM_CH, CH_ID_W, NUM_SRC=2*NUM_CH
  - dir_e {DIR_TX, DIR_RX}
  - state_e {IDLE, OFFER, BUSY, CLR}
  - source-index helper function (ch, dir) → idx
- Sub-module dma_rr_arbiter: NUM_SRC-wide request vector plus pointer in, one-hot grant plus index out. Purely combinational search; the pointer register stays in the parent.

Test Plan:
1. tx_req[3]=1, ready tied 1 → valid after 2 edges with id=3 dir=0. Done(3,0) → tx_clr[3] is a single-cycle pulse. Drop req → no re-grant.
2. tx_req[5] and rx_req[5] and rx_req[20] held high, each cleared after clr → grants in order (5,tx),(5,rx),(20,rx); then the pointer wraps to ch1 on a new req[1].
3. rx_req[7] held high after its clr for 4 cycles → no second grant. Drop 1 cycle then raise → second grant issued.
4. ch_enable[9]=0 with tx_req[9]=1 → no valid for 20 cycles. Set enable → grant id=9.
5. In BUSY for (4,tx), apply done(4,rx) → err=1, no clr, still BUSY. Then done(4,tx) → tx_clr[4] pulses.
6. Assert reset low in BUSY → all outputs 0 immediately, no clr. After release with req still high → re-granted from rr pointer 0.
